// File: rtl/halfpel_interp.sv
// Half-pel interpolation stage: turns a stream of 9-pixel integer-pel rows into
// 8 filtered 8-pixel rows per block, with the current-block row forwarded alongside.
module halfpel_interp #(
   parameter int PIX_W = 8,
   parameter int ROWS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic                 in_valid,
   input  logic [9*PIX_W-1:0]   int_pix,
   input  logic [8*PIX_W-1:0]   cur_pix,
   output logic [8*PIX_W-1:0]   filter_pix,
   output logic [8*PIX_W-1:0]   ref_pix,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 done
);

   localparam int NPIX  = 8;
   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [1:0] MODE_FULL = 2'd0;
   localparam logic [1:0] MODE_H    = 2'd1;
   localparam logic [1:0] MODE_V    = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

   state_t                 state_reg, state_next;
   logic [1:0]             mode_reg;
   logic [CNT_W-1:0]       row_cnt_reg;
   logic [9*PIX_W-1:0]     line_buf_reg;
   logic [8*PIX_W-1:0]     filter_pix_reg;
   logic [8*PIX_W-1:0]     ref_pix_reg;
   logic                   out_valid_reg;
   logic                   done_reg;

   logic                   mode_load;
   logic                   prime_load;
   logic                   run_beat;
   logic                   last_row;
   logic [8*PIX_W-1:0]     filt_row;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start)    state_next = mode[1] ? S_PRIME : S_RUN;
         S_PRIME: if (in_valid) state_next = S_RUN;
         S_RUN:   if (in_valid && last_row) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      mode_load  = (state_reg == S_IDLE) && start;
      prime_load = (state_reg == S_PRIME) && in_valid;
      run_beat   = (state_reg == S_RUN) && in_valid;
      last_row   = (row_cnt_reg == CNT_W'(ROWS - 1));
      busy       = (state_reg != S_IDLE);
   end

   // One filter lane per output pixel; a = incoming row, b = buffered previous row.
   generate
      for (genvar gi = 0; gi < NPIX; gi++) begin : g_lane
         logic [PIX_W-1:0] a0, a1, b0, b1;
         logic [PIX_W-1:0] h_res, v_res, hv_res;

         assign a0 = int_pix[gi*PIX_W +: PIX_W];
         assign a1 = int_pix[(gi+1)*PIX_W +: PIX_W];
         assign b0 = line_buf_reg[gi*PIX_W +: PIX_W];
         assign b1 = line_buf_reg[(gi+1)*PIX_W +: PIX_W];

         assign h_res  = PIX_W'(({2'b00, a0} + {2'b00, a1} + (PIX_W+2)'(1)) >> 1);
         assign v_res  = PIX_W'(({2'b00, b0} + {2'b00, a0} + (PIX_W+2)'(1)) >> 1);
         assign hv_res = PIX_W'(({2'b00, b0} + {2'b00, b1} + {2'b00, a0} + {2'b00, a1}
                                 + (PIX_W+2)'(2)) >> 2);

         assign filt_row[gi*PIX_W +: PIX_W] =
            (mode_reg == MODE_FULL) ? a0 :
            (mode_reg == MODE_H)    ? h_res :
            (mode_reg == MODE_V)    ? v_res : hv_res;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_reg       <= MODE_FULL;
         row_cnt_reg    <= '0;
         line_buf_reg   <= '0;
         filter_pix_reg <= '0;
         ref_pix_reg    <= '0;
         out_valid_reg  <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         out_valid_reg <= run_beat;
         done_reg      <= run_beat && last_row;
         if (mode_load) begin
            mode_reg <= mode;
         end
         if (prime_load || run_beat) begin
            line_buf_reg <= int_pix;
         end
         if (run_beat) begin
            filter_pix_reg <= filt_row;
            ref_pix_reg    <= cur_pix;
            row_cnt_reg    <= last_row ? '0 : row_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign filter_pix = filter_pix_reg;
   assign ref_pix    = ref_pix_reg;
   assign out_valid  = out_valid_reg;
   assign done       = done_reg;

endmodule
